// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command responder: FSM encoding, default
// opcodes/ack byte and the timeout counter width helper.
package uart_cmd_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_WR_ADDR = 3'd1;
  localparam state_t ST_WR_DATA = 3'd2;
  localparam state_t ST_RD_ADDR = 3'd3;
  localparam state_t ST_RD_WAIT = 3'd4;
  localparam state_t ST_TX_SEND = 3'd5;

  localparam logic [7:0] WR_CMD_DEF   = 8'hAA;
  localparam logic [7:0] RD_CMD_DEF   = 8'hBB;
  localparam logic [7:0] ACK_BYTE_DEF = 8'h5A;

  // Counter must hold TIMEOUT_CYC-1; never narrower than one bit.
  function automatic int tmo_width(input int cyc);
    return (cyc > 2) ? $clog2(cyc) : 1;
  endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// In-frame idle counter: clear has priority over enable, expiry is a
// combinational flag raised while enabled at TIMEOUT_CYC-1.
module uart_cmd_timeout
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = tmo_width(TIMEOUT_CYC);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)     count_d = '0;
    else if (en) count_d = count_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign expired = en && (count_q == LAST);

endmodule

// File: rtl/uart_cmd_responder.sv
// Register-access command decoder sitting behind a UART byte link.
// Define UART_CMD_WR_ACK_EN to return ACK_BYTE after every register write.
module uart_cmd_responder
  import uart_cmd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] WR_CMD = DATA_WIDTH'(WR_CMD_DEF),
  parameter logic [DATA_WIDTH-1:0] RD_CMD = DATA_WIDTH'(RD_CMD_DEF),
  parameter int TIMEOUT_CYC = 1024
`ifdef UART_CMD_WR_ACK_EN
  ,
  parameter logic [DATA_WIDTH-1:0] ACK_BYTE = DATA_WIDTH'(ACK_BYTE_DEF)
`endif
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic                  TX_BUSY,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  output logic [ADDR_WIDTH-1:0] REG_ADDR,
  output logic                  REG_WR_EN,
  output logic [DATA_WIDTH-1:0] REG_WR_DATA,
  output logic                  REG_RD_EN,
  input  logic [DATA_WIDTH-1:0] REG_RD_DATA,
  input  logic                  REG_RD_VLD,
  output logic                  CMD_ERR
);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   reg_addr_q, reg_addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic                    wr_en_q, wr_en_d;
  logic                    rd_en_q, rd_en_d;
  logic                    tx_vld_q, tx_vld_d;
  logic                    err_q, err_d;

  logic tmo_clr, tmo_en, tmo_exp, byte_acc, addr_bad;

  assign addr_bad = RX_P_DATA[DATA_WIDTH-1:ADDR_WIDTH] != '0;
  assign tmo_en   = (state_q == ST_WR_ADDR) || (state_q == ST_WR_DATA) ||
                    (state_q == ST_RD_ADDR) || (state_q == ST_RD_WAIT);

  always_comb begin
    state_d    = state_q;
    reg_addr_d = reg_addr_q;
    wr_data_d  = wr_data_q;
    tx_data_d  = tx_data_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    tx_vld_d   = 1'b0;
    err_d      = 1'b0;
    byte_acc   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == WR_CMD)      state_d = ST_WR_ADDR;
          else if (RX_P_DATA == RD_CMD) state_d = ST_RD_ADDR;
          else                          err_d   = 1'b1;
        end
      end
      ST_WR_ADDR, ST_RD_ADDR: begin
        // An arriving byte beats a coincident expiry.
        if (RX_D_VLD) begin
          byte_acc = 1'b1;
          if (addr_bad) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            reg_addr_d = RX_P_DATA[ADDR_WIDTH-1:0];
            if (state_q == ST_WR_ADDR) begin
              state_d = ST_WR_DATA;
            end else begin
              rd_en_d = 1'b1;
              state_d = ST_RD_WAIT;
            end
          end
        end else if (tmo_exp) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WR_DATA: begin
        if (RX_D_VLD) begin
          byte_acc  = 1'b1;
          wr_en_d   = 1'b1;
          wr_data_d = RX_P_DATA;
`ifdef UART_CMD_WR_ACK_EN
          tx_data_d = ACK_BYTE;
          state_d   = ST_TX_SEND;
`else
          state_d   = ST_IDLE;
`endif
        end else if (tmo_exp) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        // Stray RX bytes are flagged but never disturb the pending read.
        if (RX_D_VLD) err_d = 1'b1;
        if (REG_RD_VLD) begin
          tx_data_d = REG_RD_DATA;
          state_d   = ST_TX_SEND;
        end else if (tmo_exp) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_TX_SEND: begin
        if (RX_D_VLD) err_d = 1'b1;
        if (!TX_BUSY) begin
          tx_vld_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tmo_clr = byte_acc || (state_d != state_q);

  uart_cmd_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_tmo (
    .clk     (CLK),
    .rst     (RST),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_exp)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      reg_addr_q <= '0;
      wr_data_q  <= '0;
      tx_data_q  <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      tx_vld_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      reg_addr_q <= reg_addr_d;
      wr_data_q  <= wr_data_d;
      tx_data_q  <= tx_data_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      tx_vld_q   <= tx_vld_d;
      err_q      <= err_d;
    end
  end

  assign TX_P_DATA   = tx_data_q;
  assign TX_D_VLD    = tx_vld_q;
  assign REG_ADDR    = reg_addr_q;
  assign REG_WR_EN   = wr_en_q;
  assign REG_WR_DATA = wr_data_q;
  assign REG_RD_EN   = rd_en_q;
  assign CMD_ERR     = err_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed + randomized bench for uart_cmd_responder with a frame-level
// reference model, an external register file and a transmitter stand-in.
module tb_uart_cmd_responder;

  localparam int TMO = 1024;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] RX_P_DATA = '0;
  logic       RX_D_VLD = 1'b0;
  logic       TX_BUSY;
  logic [7:0] TX_P_DATA;
  logic       TX_D_VLD;
  logic [3:0] REG_ADDR;
  logic       REG_WR_EN;
  logic [7:0] REG_WR_DATA;
  logic       REG_RD_EN;
  logic [7:0] REG_RD_DATA = '0;
  logic       REG_RD_VLD = 1'b0;
  logic       CMD_ERR;

  always #5 CLK = ~CLK;

  uart_cmd_responder dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .TX_BUSY(TX_BUSY), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
    .REG_ADDR(REG_ADDR), .REG_WR_EN(REG_WR_EN), .REG_WR_DATA(REG_WR_DATA),
    .REG_RD_EN(REG_RD_EN), .REG_RD_DATA(REG_RD_DATA), .REG_RD_VLD(REG_RD_VLD),
    .CMD_ERR(CMD_ERR)
  );

  // Environment: register file with programmable read latency, transmitter busy model.
  int         rd_lat = 4;
  int         tx_len = 0;
  logic       busy_pre = 1'b0;
  int         busy_cnt = 0;
  int         lat = 0;
  logic [3:0] ra = '0;
  logic [7:0] mem [16] = '{default: 8'h00};

  assign TX_BUSY = busy_pre | (busy_cnt != 0);

  always @(negedge CLK) begin
    REG_RD_VLD = 1'b0;
    if (RST) begin
      lat = 0;
    end else begin
      if (lat > 0) begin
        lat = lat - 1;
        if (lat == 0) begin
          REG_RD_VLD  = 1'b1;
          REG_RD_DATA = mem[ra];
        end
      end
      if (REG_RD_EN) begin
        lat = rd_lat;
        ra  = REG_ADDR;
      end
      if (REG_WR_EN) mem[REG_ADDR] = REG_WR_DATA;
    end
    if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
    if (TX_D_VLD) busy_cnt = tx_len;
  end

  // Monitor: samples just after each rising edge.
  logic [11:0] obs_wr_q[$];
  logic [7:0]  obs_tx_q[$];
  int err_cnt = 0, rd_cnt = 0, viol_cnt = 0;

  always begin
    @(posedge CLK);
    #1;
    if (REG_WR_EN) obs_wr_q.push_back({REG_ADDR, REG_WR_DATA});
    if (TX_D_VLD)  obs_tx_q.push_back(TX_P_DATA);
    if (CMD_ERR)   err_cnt++;
    if (REG_RD_EN) rd_cnt++;
    if (int'(REG_WR_EN) + int'(REG_RD_EN) + int'(TX_D_VLD) > 1) viol_cnt++;
    if (TX_D_VLD && TX_BUSY) viol_cnt++;
  end

  // Reference model state.
  logic [7:0]  exp_regs [16] = '{default: 8'h00};
  logic [11:0] exp_wr_q[$];
  logic [7:0]  exp_tx_q[$];
  int exp_err = 0, exp_rd = 0;
  int wi = 0, ti = 0;
  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(negedge CLK);
    RX_D_VLD  = 1'b0;
  endtask

  task automatic model_write(input logic [3:0] a, input logic [7:0] d);
    exp_wr_q.push_back({a, d});
    exp_regs[a] = d;
`ifdef UART_CMD_WR_ACK_EN
    exp_tx_q.push_back(8'h5A);
`endif
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d, input int gap);
    send(8'hAA); idle(gap); send({4'h0, a}); idle(gap); send(d);
    model_write(a, d);
  endtask

  task automatic do_read(input logic [3:0] a, input int gap);
    send(8'hBB); idle(gap); send({4'h0, a});
    exp_rd++;
    exp_tx_q.push_back(exp_regs[a]);
  endtask

  task automatic settle();
    int n = 0;
    while (obs_tx_q.size() < exp_tx_q.size() && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 300) chk("settle_tx", 32'(obs_tx_q.size()), 32'(exp_tx_q.size()));
    idle(3);
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_err"},  32'(err_cnt), 32'(exp_err));
    chk({tag, "_rd"},   32'(rd_cnt),  32'(exp_rd));
    chk({tag, "_nwr"},  32'(obs_wr_q.size()), 32'(exp_wr_q.size()));
    chk({tag, "_ntx"},  32'(obs_tx_q.size()), 32'(exp_tx_q.size()));
    for (; wi < obs_wr_q.size() && wi < exp_wr_q.size(); wi++)
      chk({tag, "_wr"}, 32'(obs_wr_q[wi]), 32'(exp_wr_q[wi]));
    for (; ti < obs_tx_q.size() && ti < exp_tx_q.size(); ti++)
      chk({tag, "_tx"}, 32'(obs_tx_q[ti]), 32'(exp_tx_q[ti]));
    wi = (obs_wr_q.size() > exp_wr_q.size()) ? obs_wr_q.size() : exp_wr_q.size();
    ti = (obs_tx_q.size() > exp_tx_q.size()) ? obs_tx_q.size() : exp_tx_q.size();
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({TX_D_VLD, TX_P_DATA, REG_ADDR, REG_WR_EN, REG_WR_DATA, REG_RD_EN, CMD_ERR});
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] a;
    logic [7:0] d, b;
    int gap;

    idle(3);
    chk("reset_outputs", all_outs(), 32'h0);
    RST = 1'b0;
    idle(1);

    // Back-to-back write: strobe exactly one cycle after the data byte.
    send(8'hAA); send(8'h03); send(8'hC7);
    chk("wr_en", 32'(REG_WR_EN), 32'h1);
    chk("wr_addr", 32'(REG_ADDR), 32'h3);
    chk("wr_data", 32'(REG_WR_DATA), 32'hC7);
    model_write(4'h3, 8'hC7);
    idle(1);
    chk("wr_en_one_cycle", 32'(REG_WR_EN), 32'h0);
    settle(); compare_all("write");

    do_write(4'h5, 8'h3E, 0);
    settle(); compare_all("write2");

    // Read held off by a busy transmitter for 10 cycles.
    busy_pre = 1'b1; rd_lat = 4;
    do_read(4'h5, 0);
    idle(10);
    chk("tx_held_busy", 32'(obs_tx_q.size()), 32'(exp_tx_q.size() - 1));
    busy_pre = 1'b0;
    settle(); compare_all("read_busy");

    // Bad opcode, bad address, then a good read.
    send(8'h12); exp_err++;
    idle(2);
    send(8'hAA); send(8'hF0); exp_err++;
    settle(); compare_all("bad_frames");
    do_read(4'h5, 1);
    settle(); compare_all("read_after_err");

    // Timeout: frame abandoned after TMO idle cycles.
    send(8'hAA);
    idle(TMO - 1);
    chk("tmo_not_early", 32'(err_cnt), 32'(exp_err));
    idle(1);
    chk("tmo_err_pulse", 32'(CMD_ERR), 32'h1);
    exp_err++;
    idle(2);
    compare_all("timeout");
    do_read(4'h3, 0);
    settle(); compare_all("read_after_tmo");

    // Byte on the expiry cycle keeps the frame alive.
    send(8'hAA);
    idle(TMO - 1);
    send(8'h06); send(8'h9D);
    chk("tmo_byte_wins_wr", 32'({REG_WR_EN, REG_ADDR, REG_WR_DATA}), 32'({1'b1, 4'h6, 8'h9D}));
    model_write(4'h6, 8'h9D);
    settle(); compare_all("tmo_edge");

    // Stray byte while the read is outstanding.
    rd_lat = 8;
    do_read(4'h5, 0);
    idle(2);
    send(8'h77); exp_err++;
    settle(); compare_all("rd_wait_byte");

    // Reset in WR_DATA with a data byte on the same cycle.
    send(8'hAA); send(8'h03);
    RX_P_DATA = 8'h11; RX_D_VLD = 1'b1; RST = 1'b1;
    @(negedge CLK);
    RX_D_VLD = 1'b0;
    chk("rst_in_wr_data", all_outs(), 32'h0);
    RST = 1'b0;
    idle(2);
    compare_all("rst_wr_data");
    send(8'hC7); exp_err++;
    settle(); compare_all("after_rst_wr");

    // Reset in TX_SEND: the pending response is dropped.
    busy_pre = 1'b1; rd_lat = 1;
    send(8'hBB); send(8'h05); exp_rd++;
    idle(6);
    RST = 1'b1;
    @(negedge CLK);
    chk("rst_in_tx_send", all_outs(), 32'h0);
    RST = 1'b0; busy_pre = 1'b0;
    idle(10);
    compare_all("rst_tx_send");

    // Randomized frames against the model.
    for (int f = 0; f < 60; f++) begin
      rd_lat = $urandom_range(1, 6);
      tx_len = $urandom_range(0, 5);
      gap    = $urandom_range(0, 3);
      a      = 4'($urandom);
      d      = 8'($urandom);
      case ($urandom_range(0, 3))
        0: do_write(a, d, gap);
        1: do_read(a, gap);
        2: begin
          b = 8'($urandom);
          if (b == 8'hAA || b == 8'hBB) b = 8'h00;
          send(b); exp_err++;
        end
        default: begin
          send(($urandom_range(0, 1) != 0) ? 8'hAA : 8'hBB);
          idle(gap);
          send({4'($urandom_range(1, 15)), a}); exp_err++;
        end
      endcase
      settle();
      compare_all("rnd");
    end

    chk("no_overlap_or_busy_tx", 32'(viol_cnt), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
